bip_datapath: RTL and testbench

Accumulator datapath stage of the BIP processor, directly downstream of the `control` unit. It consumes the decoded control word (`SelA`, `SelB`, `WrAcc`, `Op`, `WrRam`, `RdRam`) and the 11-bit `Operand` in the same cycle they are produced. It holds the accumulator, the add/sub ALU, the status flags and the data RAM, so that every BIP instruction completes in one clock.

---
 rtl/bip_datapath.sv | 112 +++++++++++
 tb/tb_bip_datapath.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bip_datapath.sv
// BIP accumulator datapath: sign-extend, add/sub ALU, accumulator and flags, and a distributed data RAM.
// Latency: Acc and flags update on the edge after the control word; a RAM write is readable the next cycle.
// Backpressure: none; one instruction per cycle, and the control inputs are taken as valid on every edge.
module bip_datapath #(
    parameter int DATA_W    = 16,
    parameter int OPERAND_W = 11,
    parameter int RAM_DEPTH = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           SelA,
    input  logic                 SelB,
    input  logic                 WrAcc,
    input  logic                 Op,
    input  logic                 WrRam,
    input  logic                 RdRam,
    input  logic [OPERAND_W-1:0] Operand,
    output logic [DATA_W-1:0]    Acc,
    output logic                 Zero,
    output logic                 Carry,
    output logic                 Overflow
);

    localparam logic [1:0] SEL_RAM = 2'b00;
    localparam logic [1:0] SEL_IMM = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    logic [DATA_W-1:0] ram_q [RAM_DEPTH];

    logic [DATA_W-1:0] acc_q, acc_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   alu_sum;
    logic [DATA_W-1:0] alu_r;
    logic              alu_c;
    logic              alu_v;

    // Subtract is Acc + ~B + 1, so the carry out doubles as "no borrow".
    always_comb begin
        ext     = {{(DATA_W-OPERAND_W){Operand[OPERAND_W-1]}}, Operand};
        rdata   = RdRam ? ram_q[Operand] : '0;
        alu_b   = SelB ? ext : rdata;
        b_eff   = Op ? ~alu_b : alu_b;
        alu_sum = {1'b0, acc_q} + {1'b0, b_eff} + {{DATA_W{1'b0}}, Op};
        alu_r   = alu_sum[DATA_W-1:0];
        alu_c   = alu_sum[DATA_W];
        if (Op) begin
            alu_v = (acc_q[DATA_W-1] != alu_b[DATA_W-1]) && (alu_r[DATA_W-1] != acc_q[DATA_W-1]);
        end else begin
            alu_v = (acc_q[DATA_W-1] == alu_b[DATA_W-1]) && (alu_r[DATA_W-1] != acc_q[DATA_W-1]);
        end
    end

    always_comb begin
        acc_d   = acc_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (WrAcc) begin
            case (SelA)
                SEL_RAM: begin
                    acc_d  = rdata;
                    zero_d = (rdata == '0);
                end
                SEL_IMM: begin
                    acc_d  = ext;
                    zero_d = (ext == '0);
                end
                SEL_ALU: begin
                    acc_d   = alu_r;
                    zero_d  = (alu_r == '0);
                    carry_d = alu_c;
                    ovf_d   = alu_v;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q   <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // RAM contents survive reset; only the write is gated.
    always_ff @(posedge clk) begin
        if (reset && WrRam) begin
            ram_q[Operand] <= acc_q;
        end
    end

    assign Acc      = acc_q;
    assign Zero     = zero_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_bip_datapath.sv
// Bench for bip_datapath: directed instruction table with hand-computed results, then
// randomized instructions checked against an arithmetic reference model of the accumulator and RAM.
module tb_bip_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sel_a;
    logic        sel_b, wr_acc, op, wr_ram, rd_ram;
    logic [10:0] operand;
    logic [15:0] acc;
    logic        zero, carry, ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bip_datapath dut (
        .clk(clk), .reset(reset), .SelA(sel_a), .SelB(sel_b), .WrAcc(wr_acc), .Op(op),
        .WrRam(wr_ram), .RdRam(rd_ram), .Operand(operand),
        .Acc(acc), .Zero(zero), .Carry(carry), .Overflow(ovf)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  sela;
        logic        selb, wracc, op, wrram, rdram;
        logic [10:0] opnd;
        logic [15:0] e_acc;
        logic        e_z, e_c, e_v;
    } vec_t;

    vec_t vecs[$];

    task automatic vq(input logic rst, input logic [1:0] sa, input logic sb, input logic wa,
                      input logic o, input logic wr, input logic rd, input logic [10:0] opn,
                      input logic [15:0] ea, input logic ez, input logic ec, input logic ev);
        vec_t t;
        t.rst = rst; t.sela = sa; t.selb = sb; t.wracc = wa; t.op = o;
        t.wrram = wr; t.rdram = rd; t.opnd = opn;
        t.e_acc = ea; t.e_z = ez; t.e_c = ec; t.e_v = ev;
        vecs.push_back(t);
    endtask

    task automatic ldi(input logic [10:0] n, input logic [15:0] ea, input logic ez, input logic ec, input logic ev);
        vq(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, n, ea, ez, ec, ev);
    endtask
    task automatic st(input logic [10:0] n, input logic [15:0] ea, input logic ez, input logic ec, input logic ev);
        vq(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, n, ea, ez, ec, ev);
    endtask
    task automatic ld(input logic [10:0] n, input logic [15:0] ea, input logic ez, input logic ec, input logic ev);
        vq(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, n, ea, ez, ec, ev);
    endtask
    task automatic addi(input logic [10:0] n, input logic [15:0] ea, input logic ez, input logic ec, input logic ev);
        vq(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, n, ea, ez, ec, ev);
    endtask
    task automatic subi(input logic [10:0] n, input logic [15:0] ea, input logic ez, input logic ec, input logic ev);
        vq(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, n, ea, ez, ec, ev);
    endtask
    task automatic addm(input logic [10:0] n, input logic [15:0] ea, input logic ez, input logic ec, input logic ev);
        vq(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, n, ea, ez, ec, ev);
    endtask

    task automatic drive(input logic rst, input logic [1:0] sa, input logic sb, input logic wa,
                         input logic o, input logic wr, input logic rd, input logic [10:0] opn);
        reset = rst; sel_a = sa; sel_b = sb; wr_acc = wa; op = o;
        wr_ram = wr; rd_ram = rd; operand = opn;
    endtask

    task automatic check(input string nm, input int idx, input logic [15:0] ea,
                         input logic ez, input logic ec, input logic ev);
        checks++;
        if ({acc, zero, carry, ovf} !== {ea, ez, ec, ev}) begin
            errors++;
            $display("FAIL %s[%0d]: got acc=%h z=%b c=%b v=%b, want acc=%h z=%b c=%b v=%b",
                     nm, idx, acc, zero, carry, ovf, ea, ez, ec, ev);
        end
    endtask

    // Reference model: plain integer arithmetic on unsigned/signed interpretations.
    int m_acc, m_z, m_c, m_v;
    int m_mem[2048];
    bit m_valid[2048];

    function automatic int sx16(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    task automatic model_step(input logic rst, input logic [1:0] sa, input logic sb, input logic wa,
                              input logic o, input logic wr, input logic rd, input int opn);
        int ext, rdv, b, res, c, v, s, nacc;
        ext = (opn >= 1024) ? (opn - 2048) & 32'hFFFF : opn;
        rdv = rd ? m_mem[opn] : 0;
        b   = sb ? ext : rdv;
        if (!o) begin
            res = (m_acc + b) & 32'hFFFF;
            c   = (m_acc + b > 65535) ? 1 : 0;
            s   = sx16(m_acc) + sx16(b);
        end else begin
            res = (m_acc - b) & 32'hFFFF;
            c   = (m_acc >= b) ? 1 : 0;
            s   = sx16(m_acc) - sx16(b);
        end
        v = (s > 32767 || s < -32768) ? 1 : 0;
        if (!rst) begin
            m_acc = 0; m_z = 1; m_c = 0; m_v = 0;
        end else begin
            if (wr) begin
                m_mem[opn]   = m_acc;
                m_valid[opn] = 1'b1;
            end
            if (wa && sa != 2'b11) begin
                nacc = (sa == 2'b00) ? rdv : (sa == 2'b01) ? ext : res;
                m_acc = nacc;
                m_z = (nacc == 0) ? 1 : 0;
                if (sa == 2'b10) begin
                    m_c = c;
                    m_v = v;
                end
            end
        end
    endtask

    task automatic rand_step(input string nm, input int idx, input logic rst, input logic [1:0] sa,
                             input logic sb, input logic wa, input logic o, input logic wr,
                             input logic rd, input logic [10:0] opn);
        drive(rst, sa, sb, wa, o, wr, rd, opn);
        model_step(rst, sa, sb, wa, o, wr, rd, int'(opn));
        @(posedge clk);
        #1;
        check(nm, idx, m_acc[15:0], m_z[0], m_c[0], m_v[0]);
    endtask

    initial begin
        vq(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            vq(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        ldi(11'h7FF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        ldi(11'h3FF, 16'h03FF, 1'b0, 1'b0, 1'b0);
        ldi(11'h238, 16'h0238, 1'b0, 1'b0, 1'b0);
        addi(11'h3FF, 16'h0637, 1'b0, 1'b0, 1'b0);
        addi(11'h3FF, 16'h0A36, 1'b0, 1'b0, 1'b0);
        addi(11'h3FF, 16'h0E35, 1'b0, 1'b0, 1'b0);
        addi(11'h3FF, 16'h1234, 1'b0, 1'b0, 1'b0);
        st(11'd5, 16'h1234, 1'b0, 1'b0, 1'b0);
        ldi(11'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        ld(11'd5, 16'h1234, 1'b0, 1'b0, 1'b0);
        // Build 0x7FFF by doubling 0x3FF through RAM, then add 0x1F.
        ldi(11'h3FF, 16'h03FF, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            st(11'd7, 16'h03FF << (k - 1), 1'b0, 1'b0, 1'b0);
            addm(11'd7, 16'h03FF << k, 1'b0, 1'b0, 1'b0);
        end
        addi(11'h01F, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        addi(11'h001, 16'h8000, 1'b0, 1'b0, 1'b1);
        ldi(11'd3, 16'h0003, 1'b0, 1'b0, 1'b1);
        subi(11'd3, 16'h0000, 1'b1, 1'b1, 1'b0);
        subi(11'd1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        ldi(11'h0AA, 16'h00AA, 1'b0, 1'b0, 1'b0);
        vq(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd9, 16'h0009, 1'b0, 1'b0, 1'b0);
        ld(11'd9, 16'h00AA, 1'b0, 1'b0, 1'b0);
        ldi(11'h055, 16'h0055, 1'b0, 1'b0, 1'b0);
        vq(1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd9, 16'h0000, 1'b1, 1'b0, 1'b0);
        ld(11'd9, 16'h00AA, 1'b0, 1'b0, 1'b0);
        subi(11'd1, 16'h00A9, 1'b0, 1'b1, 1'b0);
        vq(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd9, 16'h00A9, 1'b0, 1'b1, 1'b0);
        vq(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'd9, 16'h00AA, 1'b0, 1'b1, 1'b0);
        ld(11'd9, 16'h00A9, 1'b0, 1'b1, 1'b0);
        vq(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd9, 16'h0000, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].sela, vecs[i].selb, vecs[i].wracc, vecs[i].op,
                  vecs[i].wrram, vecs[i].rdram, vecs[i].opnd);
            @(posedge clk);
            #1;
            check("dir", i, vecs[i].e_acc, vecs[i].e_z, vecs[i].e_c, vecs[i].e_v);
        end

        // Random phase: known state, then fill addresses 0..15 so every read has defined data.
        m_acc = 0; m_z = 1; m_c = 0; m_v = 0;
        rand_step("rst", 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
        for (int a = 0; a < 16; a++) begin
            rand_step("fill_ld", a, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'($urandom_range(0, 2047)));
            rand_step("fill_st", a, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'(a));
        end
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_sb, r_wa, r_op, r_wr, r_rd;
            logic [1:0]  r_sa;
            logic [10:0] r_opn;
            r_rst = ($urandom_range(0, 63) != 0);
            r_sa  = 2'($urandom_range(0, 3));
            r_sb  = 1'($urandom_range(0, 1));
            r_wa  = ($urandom_range(0, 3) != 0);
            r_op  = 1'($urandom_range(0, 1));
            r_wr  = ($urandom_range(0, 3) == 0);
            r_rd  = 1'($urandom_range(0, 1));
            r_opn = 11'($urandom_range(0, 2047));
            if ((r_rd || r_wr) && $urandom_range(0, 1) == 1)
                r_opn = 11'($urandom_range(0, 15));
            if (r_rd && !m_valid[r_opn])
                r_opn = 11'($urandom_range(0, 15));
            rand_step("rnd", i, r_rst, r_sa, r_sb, r_wa, r_op, r_wr, r_rd, r_opn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
